// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch front end: the controller
// state encoding, the default datapath width and the canonical NOP encoding.
package fetch_controller_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched instructions, each tagged with the byte
// address it was read from. The head entry is presented combinationally and
// reads as zero whenever the queue is empty. A flush empties the queue in one
// cycle and takes priority over any push or pop in the same cycle.
module fetch_queue #(
   parameter int XLEN   = 32,
   parameter int QDEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      push,
   input  logic [XLEN-1:0]           push_instr,
   input  logic [XLEN-1:0]           push_pc,
   input  logic                      pop,
   output logic [XLEN-1:0]           head_instr,
   output logic [XLEN-1:0]           head_pc,
   output logic [$clog2(QDEPTH):0]   count,
   output logic                      empty
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] instr_mem [QDEPTH];
   logic [XLEN-1:0] pc_mem    [QDEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic            full;
   logic            push_en;
   logic            pop_en;

   assign empty   = (count == '0);
   assign full    = (count == CW'(QDEPTH));
   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);

   assign head_instr = empty ? '0 : instr_mem[rd_ptr];
   assign head_pc    = empty ? '0 : pc_mem[rd_ptr];

   // Entry storage needs no reset; the pointers and count decide what is visible.
   always_ff @(posedge clk) begin
      if (push_en) begin
         instr_mem[wr_ptr] <= push_instr;
         pc_mem[wr_ptr]    <= push_pc;
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push_en) - CW'(pop_en);
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller. Walks the program from its start address in
// word steps, issuing single-cycle-latency ROM reads only while there is room
// for the response, and streams the fetched instructions with their addresses
// to decode through a valid/ready handshake. A redirect flushes everything
// buffered or in flight and restarts fetching from the new word address.
module fetch_controller #(
   parameter int XLEN   = fetch_controller_pkg::XLEN,
   parameter int QDEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] rom_size,
   output logic            rom_req,
   output logic [XLEN-1:0] rom_addr,
   input  logic [XLEN-1:0] rom_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic            fetch_complete
);

   import fetch_controller_pkg::*;

   localparam int CW = $clog2(QDEPTH) + 1;

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic            inflight;
   logic [XLEN-1:0] inflight_pc;
   logic [CW-1:0]   q_count;
   logic            q_empty;
   logic [CW:0]     occupancy;
   logic            queue_room;
   logic            redirect_take;
   logic [XLEN-1:0] redirect_target;
   logic            redirect_offset_unused;

   // A redirect is honoured everywhere except during the start-up cycle.
   assign redirect_take   = redirect_valid && (state != IDLE);
   assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

   // Fetch is word aligned, so the byte offset of a redirect target is dropped.
   assign redirect_offset_unused = ^redirect_pc[1:0];

   // Buffered entries plus the response still on its way must leave a free slot.
   assign occupancy  = {1'b0, q_count} + {{CW{1'b0}}, inflight};
   assign queue_room = occupancy < (CW+1)'(QDEPTH);

   // No new request is issued in a redirect cycle because its data would be discarded.
   assign rom_req  = reset && (state == FETCH) && !redirect_take &&
                     (pc < rom_size) && queue_room;
   assign rom_addr = pc;

   assign out_valid = !q_empty;

   fetch_queue #(
      .XLEN   (XLEN),
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_take),
      .push       (inflight),
      .push_instr (rom_rdata),
      .push_pc    (inflight_pc),
      .pop        (out_ready),
      .head_instr (out_instr),
      .head_pc    (out_pc),
      .count      (q_count),
      .empty      (q_empty)
   );

   // Controller FSM: tracks the fetch PC, the single outstanding read and completion.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         pc             <= '0;
         inflight       <= 1'b0;
         inflight_pc    <= '0;
         fetch_complete <= 1'b0;
      end else begin
         inflight <= rom_req;
         if (rom_req) begin
            inflight_pc <= pc;
         end
         case (state)
            IDLE: begin
               if (rom_size == '0) begin
                  state          <= DONE;
                  fetch_complete <= 1'b1;
               end else begin
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (redirect_take) begin
                  pc <= redirect_target;
               end else if (rom_req) begin
                  pc <= pc + XLEN'(4);
               end else if (pc >= rom_size) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (redirect_take) begin
                  state <= FETCH;
                  pc    <= redirect_target;
               end else if (q_empty && !inflight) begin
                  state          <= DONE;
                  fetch_complete <= 1'b1;
               end
            end
            DONE: begin
               if (redirect_take) begin
                  state          <= FETCH;
                  pc             <= redirect_target;
                  fetch_complete <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of PC, address and instruction.
REQ-002 SHALL have parameter QDEPTH, default 4: instruction queue entries; must be a power of 2 and at least 2.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port rom_size, input, XLEN: program size in bytes; sampled continuously.
REQ-006 SHALL have port rom_req, output, 1: instruction ROM read strobe.
REQ-007 SHALL have port rom_addr, output, XLEN: byte address of the read; word-aligned.
REQ-008 SHALL have port rom_rdata, input, XLEN: read data, valid exactly 1 cycle after rom_req.
REQ-009 SHALL have ports redirect_valid, input, 1, and redirect_pc, input, XLEN: PC redirect request and target.
REQ-010 SHALL have ports out_valid, output, 1; out_ready, input, 1; out_instr, output, XLEN; out_pc, output, XLEN: instruction stream to decode.
REQ-011 SHALL have port fetch_complete, output, 1: all instructions below rom_size delivered.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, DRAIN, DONE.
REQ-013 IDLE SHALL go to DONE if rom_size==0, else to FETCH, after one cycle.
REQ-014 In FETCH, rom_req SHALL assert with rom_addr=pc iff pc<rom_size and (queue count + in-flight) < QDEPTH; pc SHALL advance by 4 on each request.
REQ-015 FETCH SHALL go to DRAIN in the cycle pc>=rom_size with no request issued.
REQ-016 Each rom_rdata response SHALL be pushed with its request address; pushes SHALL never overflow (guaranteed by REQ-014).
REQ-017 out_valid SHALL be 1 iff the queue is non-empty; out_instr/out_pc SHALL show the head entry; pop occurs on out_valid&&out_ready.
REQ-018 Simultaneous push and pop SHALL both take effect; the count is unchanged.
REQ-019 A non-empty queue with out_ready=0 SHALL hold out_instr/out_pc stable.
REQ-020 DRAIN SHALL go to DONE when the queue is empty and nothing is in flight; fetch_complete SHALL be 1 only in DONE.
REQ-021 redirect_valid in FETCH, DRAIN or DONE SHALL, next cycle, flush the queue, discard any in-flight response, set pc to {redirect_pc[XLEN-1:2],2'b00}, and enter FETCH.
REQ-022 A pop coinciding with redirect_valid SHALL count as delivered; all remaining entries are dropped.
REQ-023 redirect_valid in IDLE SHALL be ignored.
REQ-024 Queue pointers SHALL wrap modulo QDEPTH; count width SHALL be clog2(QDEPTH)+1.

Reset
REQ-025 reset==0 at a clock edge SHALL force state IDLE, pc=0, queue empty, in-flight cleared, rom_req=0, out_valid=0, fetch_complete=0, out_instr=0, out_pc=0.
REQ-026 Reset mid-operation SHALL drop in-flight data; no queue entry from before reset shall appear after it.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, XLEN, and the instruction NOP constant 32'h00000013.
REQ-028 The queue SHALL be a separate sub-module, fetch_queue, parameterised by XLEN and QDEPTH.

Verification
REQ-029 Reset, then rom_size=16, out_ready=1 -> rom_addr 0,4,8,12; out_pc 0,4,8,12 in order; then fetch_complete=1; rom_req stays 0 afterwards.
REQ-030 rom_size=64, out_ready=0 -> exactly 4 rom_req pulses; out_valid=1, out_pc=0 held stable; no overflow.
REQ-031 Stream running; redirect_valid with redirect_pc=32'h22 -> next cycle out_valid=0, then rom_addr=32'h20; no stale instruction delivered.
REQ-032 rom_size=0 -> fetch_complete=1 two cycles after reset release; rom_req never asserted.
REQ-033 In DONE, redirect_pc=8, rom_size=16 -> fetch restarts; out_pc 8,12; then fetch_complete=1 again.
REQ-034 reset=0 asserted while a request is in flight -> all outputs at reset values on the next cycle; first out_pc after release is 0.
